// File: rtl/csr_trap_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, operation/state/mode encodings and the read-modify-write helper.
package csr_trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int IRQ_CAUSE_BASE   = 16;
  localparam int IRQ_IDX_W        = 4;

  typedef enum logic [1:0] {
    CSR_OP_WRITE = 2'b00,
    CSR_OP_SET   = 2'b01,
    CSR_OP_CLEAR = 2'b10,
    CSR_OP_RSVD  = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    TRAP = 2'b01,
    RET  = 2'b10
  } trap_state_e;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'b00,
    MTVEC_VECTORED = 2'b01
  } mtvec_mode_e;

  // New register value for a write/set/clear; the reserved op leaves it untouched.
  function automatic logic [31:0] csr_apply(input logic [1:0] op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (csr_op_e'(op))
      CSR_OP_WRITE: csr_apply = wdata;
      CSR_OP_SET:   csr_apply = old_val | wdata;
      CSR_OP_CLEAR: csr_apply = old_val & ~wdata;
      default:      csr_apply = old_val;
    endcase
  endfunction

endpackage

// File: rtl/irq_pending_unit.sv
// Interrupt pending logic: optional input synchroniser, rising-edge capture for
// edge lines, level pass-through for level lines, and a lowest-index-wins
// priority encoder over the enabled pending lines.
// Build option: `CSR_TRAP_IRQ_SYNC_EN adds a 2-flop synchroniser per line.
module irq_pending_unit
  import csr_trap_pkg::*;
#(
  parameter int                 NUM_IRQ       = 4,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE_MASK = {NUM_IRQ{1'b0}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IRQ-1:0]   irq,
  input  logic [NUM_IRQ-1:0]   enable,
  input  logic [NUM_IRQ-1:0]   sw_clear,
  input  logic [NUM_IRQ-1:0]   take_clear,
  output logic [NUM_IRQ-1:0]   pending,
  output logic                 irq_valid,
  output logic [IRQ_IDX_W-1:0] irq_index
);

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] prev_reg;
  logic [NUM_IRQ-1:0] edge_pend_reg;
  logic [NUM_IRQ-1:0] edge_pend_next;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] masked;

`ifdef CSR_TRAP_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_reg;
  logic [NUM_IRQ-1:0] sync2_reg;

  // Two-stage synchroniser for asynchronous interrupt sources.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= irq;
      sync2_reg <= sync1_reg;
    end
  end

  assign irq_s = sync2_reg;
`else
  assign irq_s = irq;
`endif

  // A rise is visible as pending in the same cycle so the trap latency is one edge.
  assign rise = irq_s & ~prev_reg;

  // Set beats a software clear; taking the trap consumes the event outright.
  assign edge_pend_next = ((edge_pend_reg & ~sw_clear) | rise) & ~take_clear & IRQ_EDGE_MASK;

  // Previous-sample and captured-edge registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_reg      <= '0;
      edge_pend_reg <= '0;
    end else begin
      prev_reg      <= irq_s;
      edge_pend_reg <= edge_pend_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
      if (IRQ_EDGE_MASK[gi]) begin : g_edge
        assign pending[gi] = edge_pend_reg[gi] | rise[gi];
      end else begin : g_level
        assign pending[gi] = irq_s[gi];
      end
    end
  endgenerate

  assign masked = pending & enable;

  // Priority encoder: scanning downward leaves the lowest set index as winner.
  always_comb begin
    irq_valid = 1'b0;
    irq_index = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) begin
        irq_valid = 1'b1;
        irq_index = IRQ_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for the 2-stage RV32 core.
// Takes prioritised local interrupts and mret, and drives a held redirect
// request to the fetch PC mux until the pipeline acknowledges it.
// Build option: `CSR_TRAP_IRQ_SYNC_EN synchronises irq inputs (see irq_pending_unit).
module csr_trap_unit
  import csr_trap_pkg::*;
#(
  parameter int                 NUM_IRQ       = 4,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE_MASK = {NUM_IRQ{1'b0}},
  parameter logic [31:0]        MTVEC_RESET   = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               csr_wr,
  input  logic               csr_rd,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  input  logic               commit_valid,
  input  logic [31:0]        commit_pc,
  input  logic               is_mret,
  output logic               redirect_req,
  output logic [31:0]        redirect_pc,
  input  logic               redirect_ack
);

  trap_state_e state_reg, state_next;
  logic               mstatus_mie_reg, mstatus_mpie_reg;
  logic [NUM_IRQ-1:0] mie_reg;
  logic [31:0]        mtvec_reg, mepc_reg, mcause_reg, redirect_pc_reg;

  logic [NUM_IRQ-1:0]   pending, sw_clear, take_clear;
  logic                 irq_valid;
  logic [IRQ_IDX_W-1:0] irq_index;
  logic [31:0] mstatus_word, mie_word, mip_word;
  logic [31:0] csr_value, csr_new, trap_base, trap_target;
  logic [4:0]  trap_cause;
  logic        addr_hit, wr_en, take_mret, take_trap;

  irq_pending_unit #(
    .NUM_IRQ       (NUM_IRQ),
    .IRQ_EDGE_MASK (IRQ_EDGE_MASK)
  ) u_pending (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .enable     (mie_reg),
    .sw_clear   (sw_clear),
    .take_clear (take_clear),
    .pending    (pending),
    .irq_valid  (irq_valid),
    .irq_index  (irq_index)
  );

  // Architectural views of the CSRs; interrupt line i lives at bit 16+i.
  always_comb begin
    mstatus_word = '0;
    mstatus_word[MSTATUS_MIE_BIT]  = mstatus_mie_reg;
    mstatus_word[MSTATUS_MPIE_BIT] = mstatus_mpie_reg;
    mie_word = '0;
    mip_word = '0;
    mie_word[IRQ_CAUSE_BASE +: NUM_IRQ] = mie_reg;
    mip_word[IRQ_CAUSE_BASE +: NUM_IRQ] = pending;
  end

  // CSR read mux; also provides the old value for read-modify-write ops.
  always_comb begin
    csr_value = '0;
    addr_hit  = 1'b1;
    case (csr_addr)
      CSR_MSTATUS: csr_value = mstatus_word;
      CSR_MIE:     csr_value = mie_word;
      CSR_MTVEC:   csr_value = mtvec_reg;
      CSR_MEPC:    csr_value = mepc_reg;
      CSR_MCAUSE:  csr_value = mcause_reg;
      CSR_MIP:     csr_value = mip_word;
      default:     addr_hit  = 1'b0;
    endcase
  end

  assign csr_rdata = csr_rd ? csr_value : 32'h0;
  assign csr_new   = csr_apply(csr_op, csr_value, csr_wdata);
  assign wr_en     = csr_wr && (csr_op != CSR_OP_RSVD) && addr_hit;

  // mip is read-only except that software may clear captured edge events.
  assign sw_clear = (wr_en && csr_addr == CSR_MIP) ?
                    (~csr_new[IRQ_CAUSE_BASE +: NUM_IRQ] & IRQ_EDGE_MASK) : '0;

  assign take_mret  = (state_reg == RUN) && commit_valid && is_mret;
  assign take_trap  = (state_reg == RUN) && commit_valid && !is_mret && mstatus_mie_reg && irq_valid;
  assign take_clear = take_trap ? (NUM_IRQ'(1) << irq_index) : '0;

  assign trap_cause  = 5'(IRQ_CAUSE_BASE) + {1'b0, irq_index};
  assign trap_base   = {mtvec_reg[31:2], 2'b00};
  assign trap_target = (mtvec_mode_e'(mtvec_reg[1:0]) == MTVEC_VECTORED) ?
                       trap_base + {25'b0, trap_cause, 2'b00} : trap_base;

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= RUN;
    else        state_reg <= state_next;
  end

  // Next state: mret has priority over an interrupt; redirect held until ack.
  always_comb begin
    state_next   = state_reg;
    redirect_req = 1'b0;
    case (state_reg)
      RUN: begin
        if (take_mret)      state_next = RET;
        else if (take_trap) state_next = TRAP;
      end
      TRAP, RET: begin
        redirect_req = 1'b1;
        if (redirect_ack) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign redirect_pc = redirect_pc_reg;

  // CSR updates; trap/mret hardware updates come last so they override writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= '0;
      mtvec_reg        <= MTVEC_RESET;
      mepc_reg         <= '0;
      mcause_reg       <= '0;
      redirect_pc_reg  <= '0;
    end else begin
      if (wr_en && csr_addr == CSR_MSTATUS) begin
        mstatus_mie_reg  <= csr_new[MSTATUS_MIE_BIT];
        mstatus_mpie_reg <= csr_new[MSTATUS_MPIE_BIT];
      end
      if (wr_en && csr_addr == CSR_MIE)    mie_reg    <= csr_new[IRQ_CAUSE_BASE +: NUM_IRQ];
      if (wr_en && csr_addr == CSR_MTVEC)  mtvec_reg  <= csr_new;
      if (wr_en && csr_addr == CSR_MEPC)   mepc_reg   <= csr_new & 32'hFFFF_FFFC;
      if (wr_en && csr_addr == CSR_MCAUSE) mcause_reg <= csr_new;
      if (take_mret) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
        redirect_pc_reg  <= mepc_reg;
      end else if (take_trap) begin
        mepc_reg         <= commit_pc & 32'hFFFF_FFFC;
        mcause_reg       <= {1'b1, 26'b0, trap_cause};
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
        redirect_pc_reg  <= trap_target;
      end
    end
  end

endmodule
